fun_root_mul: RTL and testbench

- Parametrised successor of the fixed 8-bit a*cbrt(b) unit: computes y = a * floor(root_k(b)).
- Width is set by a parameter; the root order (cube or square) is selected per operation.
- Sequential iterative root engine and shift-add multiplier share one adder/subtractor.
- Sits as a multi-cycle arithmetic slave behind a start/busy/done handshake in the datapath.

---
 rtl/fun_root_mul.sv | 194 +++++++++++++++++++
 tb/tb_fun_root_mul.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fun_root_mul.sv
// fun_root_mul: result = a * floor(root_k(b)), k=3 (mode_i=0) or k=2 (mode_i=1), iterative on one shared adder.
// Define FUN_REM_EN to add the rem port (b - root^k).
module fun_root_mul #(
    parameter int W  = 8,
    parameter int RW = (W + 1) / 2,
    parameter int OW = W + RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode_i,
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    output logic          busy,
    output logic          done,
    output logic [OW-1:0] result
`ifdef FUN_REM_EN
    ,
    output logic [W-1:0]  rem
`endif
);
    localparam int CN = (W + 2) / 3;
    localparam int XW = (3 * CN > 2 * RW) ? 3 * CN : 2 * RW;
    localparam int CW = $clog2(RW + 1);
    localparam int AW = 2 * W;

    typedef enum logic [1:0] {S_IDLE, S_ROOT, S_MUL, S_FIN} state_t;
    state_t r_state, w_next;

    logic          r_mode, r_done;
    logic [W-1:0]  r_a, r_r;
    logic [XW-1:0] r_x;
    logic [RW-1:0] r_y;
    logic [AW-1:0] r_p, r_t;
    logic [OW-1:0] r_acc, r_result;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_ph;

    logic [W-1:0]  w_rs, w_rc;
    logic [AW-1:0] w_opa, w_opb;
    logic [AW:0]   w_sum;
    logic          w_sub, w_cin, w_c, w_last, w_iter_end;

    // Remainder with the next radicand digit group shifted in; upper bits are provably zero.
    assign w_rs       = {r_r[W-3:0], r_x[XW-1 -: 2]};
    assign w_rc       = {r_r[W-4:0], r_x[XW-1 -: 3]};
    assign w_last     = r_cnt == CW'(1);
    assign w_iter_end = r_mode | (r_ph == 2'd3);
    assign w_sum      = {1'b0, w_opa} + {1'b0, w_sub ? ~w_opb : w_opb} + {{AW{1'b0}}, w_cin};
    assign w_c        = w_sum[AW];

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_ROOT : S_IDLE;
            S_ROOT:  w_next = (w_iter_end && w_last) ? S_MUL : S_ROOT;
            S_MUL:   w_next = w_last ? S_FIN : S_MUL;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = r_state != S_IDLE;
    end

    // Cube phases keep p = y*(y+1): p' = 4p - 2y on doubling, t = 3p' + 1, then p' += 2y if the digit was 1.
    always_comb begin
        w_opa = '0;
        w_opb = '0;
        w_sub = 1'b0;
        w_cin = 1'b0;
        if (r_state == S_MUL) begin
            w_opa = AW'(r_acc) << 1;
            w_opb = r_y[RW-1] ? AW'(r_a) : '0;
        end else if (r_state == S_ROOT && r_mode) begin
            w_opa = AW'(w_rs);
            w_opb = AW'({r_y, 2'b01});
            w_sub = 1'b1;
            w_cin = 1'b1;
        end else if (r_state == S_ROOT) begin
            case (r_ph)
                2'd0: begin
                    w_opa = r_p << 2;
                    w_opb = AW'(r_y) << 1;
                    w_sub = 1'b1;
                    w_cin = 1'b1;
                end
                2'd1: begin
                    w_opa = r_p;
                    w_opb = r_p << 1;
                    w_cin = 1'b1;
                end
                2'd2: begin
                    w_opa = AW'(r_r);
                    w_opb = r_t;
                    w_sub = 1'b1;
                    w_cin = 1'b1;
                end
                default: begin
                    w_opa = r_p;
                    w_opb = r_y[0] ? AW'(r_y) << 1 : '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode   <= 1'b0;
            r_a      <= '0;
            r_r      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_p      <= '0;
            r_t      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ph     <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= (r_state == S_MUL) && w_last;
            case (r_state)
                S_IDLE: if (start) begin
                    r_a   <= a_i;
                    r_mode <= mode_i;
                    r_x   <= mode_i ? XW'(b_i) << (XW - 2 * RW) : XW'(b_i) << (XW - 3 * CN);
                    r_r   <= '0;
                    r_y   <= '0;
                    r_p   <= '0;
                    r_ph  <= '0;
                    r_acc <= '0;
                    r_cnt <= mode_i ? CW'(RW) : CW'(CN);
                end
                S_ROOT: if (r_mode) begin
                    r_x   <= r_x << 2;
                    r_r   <= w_c ? w_sum[W-1:0] : w_rs;
                    r_y   <= {r_y[RW-2:0], w_c};
                    r_cnt <= w_last ? CW'(RW) : r_cnt - CW'(1);
                end else begin
                    r_ph <= r_ph + 2'd1;
                    case (r_ph)
                        2'd0: begin
                            r_x <= r_x << 3;
                            r_r <= w_rc;
                            r_y <= r_y << 1;
                            r_p <= w_sum[AW-1:0];
                        end
                        2'd1: r_t <= w_sum[AW-1:0];
                        2'd2: begin
                            r_r <= w_c ? w_sum[W-1:0] : r_r;
                            r_y <= {r_y[RW-1:1], w_c};
                        end
                        default: begin
                            r_p   <= w_sum[AW-1:0];
                            r_cnt <= w_last ? CW'(RW) : r_cnt - CW'(1);
                        end
                    endcase
                end
                S_MUL: begin
                    r_acc <= w_sum[OW-1:0];
                    r_y   <= r_y << 1;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last)
                        r_result <= w_sum[OW-1:0];
                end
                default: ;
            endcase
        end
    end

    assign done   = r_done;
    assign result = r_result;

`ifdef FUN_REM_EN
    logic [W-1:0] r_rem;

    always_ff @(posedge clk) begin
        if (!rst)
            r_rem <= '0;
        else if (r_state == S_MUL && w_last)
            r_rem <= r_r;
    end

    assign rem = r_rem;
`endif
endmodule

// File: tb/tb_fun_root_mul.sv
// tb_fun_root_mul: directed and randomized checks of fun_root_mul at W=8 and W=16
// against a search-based integer-root reference model.
`timescale 1ns/1ps
module tb_fun_root_mul;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        st8 = 1'b0, m8 = 1'b0, busy8, done8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [11:0] res8;
    logic        st16 = 1'b0, m16 = 1'b0, busy16, done16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [23:0] res16;
`ifdef FUN_REM_EN
    logic [7:0]  rem8;
    logic [15:0] rem16;
`endif

    int n_chk = 0;
    int n_err = 0;
    int lat_ref[2][2];

    fun_root_mul #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .mode_i(m8), .a_i(a8), .b_i(b8),
        .busy(busy8), .done(done8), .result(res8)
`ifdef FUN_REM_EN
        , .rem(rem8)
`endif
    );

    fun_root_mul #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .start(st16), .mode_i(m16), .a_i(a16), .b_i(b16),
        .busy(busy16), .done(done16), .result(res16)
`ifdef FUN_REM_EN
        , .rem(rem16)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned iroot(input longint unsigned b, input bit sq);
        longint unsigned y = 0;
        while ((sq ? (y + 1) * (y + 1) : (y + 1) * (y + 1) * (y + 1)) <= b)
            y++;
        return y;
    endfunction

    function automatic logic wbusy(input bit wd);
        return wd ? busy16 : busy8;
    endfunction

    function automatic logic wdone(input bit wd);
        return wd ? done16 : done8;
    endfunction

    function automatic logic [63:0] wres(input bit wd);
        return wd ? 64'(res16) : 64'(res8);
    endfunction

    task automatic drive(input bit wd, input logic s, input bit m, input int a, input int b);
        if (wd) begin
            st16 = s; m16 = m; a16 = 16'(a); b16 = 16'(b);
        end else begin
            st8 = s; m8 = m; a8 = 8'(a); b8 = 8'(b);
        end
    endtask

    task automatic release_start(input bit wd);
        if (wd) st16 = 1'b0; else st8 = 1'b0;
    endtask

    // Called right after a negedge; returns at the negedge following the FIN cycle.
    task automatic op(input bit wd, input bit m, input int a, input int b,
                      input int poke, input bit poke_fin, input string tag);
        int rw = wd ? 8 : 4;
        longint unsigned y = iroot(longint'(b), m);
        longint unsigned exp_res = longint'(a) * y;
        longint unsigned exp_rem = longint'(b) - (m ? y * y : y * y * y);
        int lat;
        drive(wd, 1'b1, m, a, b);
        @(negedge clk);
        lat = 1;
        release_start(wd);
        chk({tag, "/busy"}, 64'(wbusy(wd)), 1);
        while (!wdone(wd) && lat < 200) begin
            @(negedge clk);
            lat++;
            release_start(wd);
            if (lat == poke)
                drive(wd, 1'b1, ~m, 1, 8);
        end
        chk({tag, "/done"}, 64'(wdone(wd)), 1);
        chk({tag, "/lat_bound"}, 64'(lat <= 5 * rw + 2), 1);
        if (lat_ref[wd][m] == 0)
            lat_ref[wd][m] = lat;
        else
            chk({tag, "/lat_const"}, 64'(lat), 64'(lat_ref[wd][m]));
        chk({tag, "/result"}, wres(wd), exp_res);
`ifdef FUN_REM_EN
        chk({tag, "/rem"}, wd ? 64'(rem16) : 64'(rem8), exp_rem);
`endif
        if (poke_fin)
            drive(wd, 1'b1, ~m, 1, 8);
        @(negedge clk);
        release_start(wd);
        chk({tag, "/done_pulse"}, 64'(wdone(wd)), 0);
        chk({tag, "/idle"}, 64'(wbusy(wd)), 0);
        chk({tag, "/held"}, wres(wd), exp_res);
    endtask

    initial begin
        int nd;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                lat_ref[i][j] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst/busy8", 64'(busy8), 0);
        chk("rst/done8", 64'(done8), 0);
        chk("rst/res8", 64'(res8), 0);
        chk("rst/busy16", 64'(busy16), 0);
        chk("rst/done16", 64'(done16), 0);
        chk("rst/res16", 64'(res16), 0);
`ifdef FUN_REM_EN
        chk("rst/rem8", 64'(rem8), 0);
        chk("rst/rem16", 64'(rem16), 0);
`endif

        op(1'b0, 1'b0, 10, 27, -1, 1'b0, "cube_10_27");
        op(1'b0, 1'b1, 255, 255, -1, 1'b0, "sqrt_255_255");
        op(1'b0, 1'b1, 200, 0, -1, 1'b0, "sqrt_b0");
        op(1'b0, 1'b0, 7, 30, 5, 1'b1, "cube_7_30_poke");
        op(1'b0, 1'b0, 0, 200, -1, 1'b0, "cube_a0");
        op(1'b0, 1'b0, 255, 255, -1, 1'b0, "cube_max");
        op(1'b1, 1'b0, 1000, 65535, -1, 1'b0, "w16_cube");
        op(1'b1, 1'b1, 65535, 65535, -1, 1'b1, "w16_sqrt_max");

        // Abort mid-MUL: square root at W=8 is in MUL during cycles 5..8.
        drive(1'b0, 1'b1, 1'b1, 200, 200);
        @(negedge clk);
        release_start(1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort/busy", 64'(busy8), 0);
        chk("abort/done", 64'(done8), 0);
        chk("abort/result", 64'(res8), 0);
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("abort/no_done", 64'(nd), 0);
        op(1'b0, 1'b1, 3, 16, -1, 1'b0, "after_abort");
        op(1'b0, 1'b1, 9, 100, -1, 1'b0, "b2b_sqrt");
        op(1'b0, 1'b0, 9, 100, -1, 1'b0, "b2b_cube");

        for (int i = 0; i < 40; i++) begin
            int sel = int'($urandom_range(0, 7));
            int b = sel == 0 ? 0 : sel == 1 ? 255 : int'($urandom_range(0, 255));
            op(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), b, -1, 1'b0, "rnd8");
        end
        for (int i = 0; i < 20; i++) begin
            int sel = int'($urandom_range(0, 7));
            int b = sel == 0 ? 0 : sel == 1 ? 65535 : int'($urandom_range(0, 65535));
            op(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), b, -1, 1'b0, "rnd16");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
